// File: rtl/btn_debouncer.sv
// Button debouncer with rise/fall pulses and optional long-press detection.
// A 2-flop synchronizer feeds a four-state FSM. A level change is accepted only
// after the synchronized input has stayed at the new value for DB_CYCLES
// consecutive cycles past the first change.
// Optional feature: define BTN_LONGPRESS_EN to enable the long_press pulse.
// Without it, long_press is tied to 0 and the port list is unchanged.
module btn_debouncer #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned LP_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_db,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int unsigned MaxCycles = (DB_CYCLES > LP_CYCLES) ? DB_CYCLES : LP_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] DbLast = CntW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    StLow,
    StChkHigh,
    StHigh,
    StChkLow
  } state_e;

  logic            sync1;
  logic            sync2;
  logic            s;
  logic [CntW-1:0] cnt;
  state_e          state;

  assign s = sync2;

  // Two-flop synchronizer for the raw asynchronous button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam logic [CntW-1:0] LpLast = CntW'(LP_CYCLES - 1);

  // Set once long_press has fired; cleared only when a release is accepted so a
  // rejected release bounce cannot produce a second pulse.
  logic lp_fired;

  // Debounce FSM with registered level, edge pulses and long-press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StLow;
      cnt        <= '0;
      btn_db     <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
      lp_fired   <= 1'b0;
    end else begin
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
      unique case (state)
        StLow: begin
          if (s) begin
            state <= StChkHigh;
            cnt   <= '0;
          end
        end
        StChkHigh: begin
          if (!s) begin
            state <= StLow;
          end else if (cnt == DbLast) begin
            state  <= StHigh;
            cnt    <= '0;
            btn_db <= 1'b1;
            rise   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StHigh: begin
          if (!s) begin
            state <= StChkLow;
            cnt   <= '0;
          end else if (cnt != LpLast) begin
            cnt <= cnt + 1'b1;
          end else if (!lp_fired) begin
            // cnt saturates at LpLast; the pulse fires once per accepted press
            long_press <= 1'b1;
            lp_fired   <= 1'b1;
          end
        end
        StChkLow: begin
          if (s) begin
            state <= StHigh;
            cnt   <= '0;
          end else if (cnt == DbLast) begin
            state    <= StLow;
            btn_db   <= 1'b0;
            fall     <= 1'b1;
            lp_fired <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StLow;
      endcase
    end
  end
`else
  assign long_press = 1'b0;

  // Debounce FSM with registered level and edge pulses; no counting in StHigh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= StLow;
      cnt    <= '0;
      btn_db <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        StLow: begin
          if (s) begin
            state <= StChkHigh;
            cnt   <= '0;
          end
        end
        StChkHigh: begin
          if (!s) begin
            state <= StLow;
          end else if (cnt == DbLast) begin
            state  <= StHigh;
            cnt    <= '0;
            btn_db <= 1'b1;
            rise   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StHigh: begin
          if (!s) begin
            state <= StChkLow;
            cnt   <= '0;
          end
        end
        StChkLow: begin
          if (s) begin
            state <= StHigh;
            cnt   <= '0;
          end else if (cnt == DbLast) begin
            state  <= StLow;
            btn_db <= 1'b0;
            fall   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StLow;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_btn_debouncer.sv
// Testbench for btn_debouncer (DB_CYCLES=4, LP_CYCLES=20). Outputs are checked
// every cycle against a reference model: a debounced level flips once the last
// DB+1 synchronized samples all differ from it; long press fires when the
// synchronized input has stayed high for LP cycles after (re)entering high.
module tb_btn_debouncer;

  localparam int DB = 4;
  localparam int LP = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic btn_db;
  logic rise;
  logic fall;
  logic long_press;

  btn_debouncer #(
    .DB_CYCLES(DB),
    .LP_CYCLES(LP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .btn_db    (btn_db),
    .rise      (rise),
    .fall      (fall),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state
  bit m1, m2, db, prev_s, fired;
  int held;
  bit hist[$];
  bit e_rise, e_fall, e_lp;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m1 = 0; m2 = 0; db = 0; prev_s = 0; fired = 0; held = 0;
    hist.delete();
    e_rise = 0; e_fall = 0; e_lp = 0;
  endfunction

  function automatic void model_edge(input bit b);
    bit s;
    bit all_diff;
    s  = m2;
    m2 = m1;
    m1 = b;
    e_rise = 0; e_fall = 0; e_lp = 0;
    hist.push_back(s);
    if (hist.size() > DB + 1) void'(hist.pop_front());
    all_diff = (hist.size() == DB + 1);
    foreach (hist[i]) if (hist[i] == db) all_diff = 0;
    if (all_diff) begin
      db = ~db;
      if (db) begin
        e_rise = 1;
        held   = 0;
      end else begin
        e_fall = 1;
        fired  = 0;
      end
    end else if (db && s) begin
      if (prev_s) begin
        held++;
        if (held == LP && !fired) begin
          fired = 1;
`ifdef BTN_LONGPRESS_EN
          e_lp = 1;
`endif
        end
      end else begin
        held = 0;
      end
    end
    prev_s = s;
  endfunction

  task automatic step(input bit b);
    btn = b;
    @(posedge clk);
    model_edge(b);
    #1;
    chk("btn_db", btn_db, db);
    chk("rise", rise, e_rise);
    chk("fall", fall, e_fall);
    chk("long_press", long_press, e_lp);
    chk("rise_fall_excl", rise & fall, 1'b0);
  endtask

  initial begin
    int t;
    int lp_cnt;
    int lp_at;
    int len;
    bit b;

    // Reset state
    rst = 1'b1;
    btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_btn_db", btn_db, 1'b0);
    chk("rst_rise", rise, 1'b0);
    chk("rst_fall", fall, 1'b0);
    chk("rst_long_press", long_press, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) step(1'b0);

    // Clean press: accepted on the 7th edge counting the first sampling edge
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      chk("press_early_db", btn_db, 1'b0);
    end
    step(1'b1);
    chk("press_lat_rise", rise, 1'b1);
    chk("press_lat_db", btn_db, 1'b1);
    step(1'b1);
    chk("press_rise_once", rise, 1'b0);
    repeat (12) step(1'b1);

    // Clean release
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      chk("release_early_db", btn_db, 1'b1);
    end
    step(1'b0);
    chk("release_lat_fall", fall, 1'b1);
    chk("release_lat_db", btn_db, 1'b0);
    step(1'b0);
    chk("release_fall_once", fall, 1'b0);
    repeat (4) step(1'b0);

    // Short press bounce is rejected
    repeat (3) step(1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      chk("bounce_db", btn_db, 1'b0);
    end

    // Accepted press followed by a 2-cycle low glitch
    repeat (10) step(1'b1);
    chk("glitch_pre_db", btn_db, 1'b1);
    repeat (2) step(1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      chk("glitch_db", btn_db, 1'b1);
    end
    repeat (10) step(1'b0);

    // Long press: held 40 cycles after acceptance
    t = 0;
    while (!btn_db && t < 20) begin
      step(1'b1);
      t++;
    end
    chk("lp_accept", btn_db, 1'b1);
    lp_cnt = 0;
    lp_at  = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1);
      if (long_press) begin
        lp_cnt++;
        lp_at = i;
      end
    end
`ifdef BTN_LONGPRESS_EN
    chk_int("lp_count", lp_cnt, 1);
    chk_int("lp_offset", lp_at, LP);
`else
    chk_int("lp_count", lp_cnt, 0);
`endif
    // Release bounce then hold again: no second pulse
    repeat (2) step(1'b0);
    lp_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1);
      if (long_press) lp_cnt++;
    end
    chk_int("lp_no_repeat", lp_cnt, 0);
    repeat (10) step(1'b0);

    // Random bursts
    repeat (150) begin
      b   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      repeat (len) step(b);
    end

    // Reset while high with btn held
    repeat (10) step(1'b1);
    chk("rst_pre_db", btn_db, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_btn_db", btn_db, 1'b0);
    chk("rst_mid_fall", fall, 1'b0);
    chk("rst_mid_rise", rise, 1'b0);
    chk("rst_mid_long_press", long_press, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_fall", fall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      chk("post_rst_early_db", btn_db, 1'b0);
    end
    step(1'b1);
    chk("post_rst_rise", rise, 1'b1);
    step(1'b1);
    chk("post_rst_rise_once", rise, 1'b0);
    repeat (5) step(1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/btn_debouncer.md
BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, stable-sample count needed to accept a level change; legal range >= 1.
REQ-002 Parameter LP_CYCLES, default 100000000, count of cycles in HIGH that marks a long press; legal range >= 1.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port btn, input, 1, raw asynchronous button or switch level, may bounce.
REQ-006 Port btn_db, output, 1, debounced registered level; feeds the downstream button-to-switch toggle stage.
REQ-007 Port rise, output, 1, single-cycle pulse on an accepted 0->1 change.
REQ-008 Port fall, output, 1, single-cycle pulse on an accepted 1->0 change.
REQ-009 Port long_press, output, 1, single-cycle pulse on a long-press event.

Function
REQ-010 btn SHALL pass through a 2-flop synchronizer (sync1, sync2); only sync2 (s) drives the FSM.
REQ-011 The FSM SHALL have states LOW, CHK_HIGH, HIGH, CHK_LOW and one counter cnt, width $clog2(max(DB_CYCLES, LP_CYCLES)) + 1.
REQ-012 LOW: s=1 -> CHK_HIGH, cnt<=0; else stay.
REQ-013 CHK_HIGH: s=0 -> LOW (bounce rejected, no pulse); s=1 and cnt==DB_CYCLES-1 -> HIGH, cnt<=0; else cnt<=cnt+1.
REQ-014 HIGH: s=0 -> CHK_LOW, cnt<=0; else long-press counting per REQ-021.
REQ-015 CHK_LOW: s=1 -> HIGH (bounce rejected); s=0 and cnt==DB_CYCLES-1 -> LOW; else cnt<=cnt+1.
REQ-016 btn_db SHALL be 1 exactly while the state is HIGH or CHK_LOW; it is registered, not decoded combinationally from s.
REQ-017 rise SHALL be 1 for exactly the one cycle in which btn_db first reads 1; fall SHALL be 1 for exactly the one cycle in which btn_db first reads 0.
REQ-018 Latency: if edge k is the first edge sampling a stable btn=1, btn_db and rise SHALL read 1 after edge k+DB_CYCLES+2. The same latency SHALL apply to release and fall.
REQ-019 rise and fall SHALL never both be 1 in one cycle.
REQ-020 A glitch shorter than DB_CYCLES synchronized cycles SHALL produce no output change.

Configuration
REQ-021 With macro BTN_LONGPRESS_EN defined:
- In HIGH, cnt SHALL increment while s=1.
- long_press SHALL pulse one cycle on the edge where cnt reaches LP_CYCLES-1; cnt then saturates.
- No further pulse SHALL occur until after a release is accepted.
- Entering CHK_LOW SHALL stop counting; a rejected release bounce (return to HIGH) restarts the count from 0.
REQ-022 Without BTN_LONGPRESS_EN:
- long_press SHALL be tied to constant 0.
- cnt SHALL not count in HIGH.
- The port list SHALL be identical in both builds.

Reset
REQ-023 While rst=1, independent of clk, the block SHALL hold sync1, sync2 and cnt at 0, state at LOW, and btn_db, rise, fall and long_press at 0.
REQ-024 Reset asserted mid-operation (any state) SHALL drop all outputs to 0 immediately with no fall pulse.
REQ-025 After rst deasserts with btn held high, the block SHALL run a full debounce and emit rise per REQ-018.

Verification (DB_CYCLES=4, LP_CYCLES=20)
REQ-026 Clean press: btn 0->1, held 20 cycles -> btn_db=1 and rise=1 after edge k+6; rise=0 from edge k+7 on; fall=0 throughout.
REQ-027 Bounce: btn high for 3 cycles, then low -> btn_db, rise and fall stay 0 throughout.
REQ-028 Release: btn 1->0 held after an accepted press -> btn_db=0 and fall=1 for one cycle, 6 edges after the first edge sampling 0; a 2-cycle low glitch instead -> btn_db stays 1.
REQ-029 Long press, held 40 cycles after acceptance:
- With BTN_LONGPRESS_EN: exactly one long_press pulse, 20 edges after btn_db rises.
- Without BTN_LONGPRESS_EN: long_press stays 0.
REQ-030 Reset in HIGH with btn held 1 -> outputs 0 at once, no fall; after rst deasserts, rise=1 at deassert edge +6.
